// File: rtl/led_pkg.sv
// Shared constants for the LED PWM/blink block: register map, CTRL bit
// positions and CTRL reset value.
package led_pkg;

    localparam logic [1:0] ADDR_CTRL       = 2'd0;
    localparam logic [1:0] ADDR_DUTY       = 2'd1;
    localparam logic [1:0] ADDR_PRESCALE   = 2'd2;
    localparam logic [1:0] ADDR_BLINK_HALF = 2'd3;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_BLINK_EN = 1;
    localparam int CTRL_INVERT   = 2;
    localparam int CTRL_BITS     = 3;

    // Enabled, no blink, normal polarity.
    localparam logic [CTRL_BITS-1:0] CTRL_RESET = 3'b001;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler plus free-running PWM counter. Produces the PWM tick, the
// current PWM count and a one-cycle pulse at the last tick of each period.
module led_tick_gen #(
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE_BITS = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PRESCALE_BITS-1:0] prescale,
    output logic                     tick,
    output logic [PWM_BITS-1:0]      pwm_cnt,
    output logic                     per_end
);

    logic [PRESCALE_BITS-1:0] pre_cnt;

    // >= rather than == so that lowering PRESCALE below the running count
    // ticks on the next cycle instead of waiting for a full counter wrap.
    assign tick    = (pre_cnt >= prescale);
    assign per_end = tick && (pwm_cnt == {PWM_BITS{1'b1}});

    // Prescaler restarts on each tick; PWM counter advances on tick and wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            if (tick) pre_cnt <= '0;
            else      pre_cnt <= pre_cnt + 1'b1;
            if (tick) pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_pwm_blinker.sv
// LED driver behind the PIO: registers the pattern, applies PWM dimming,
// optional blinking and polarity inversion. Configured via a 4-register
// zero-wait Avalon-MM slave.
module led_pwm_blinker
    import led_pkg::*;
#(
    parameter int NUM_LEDS      = 8,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_LEDS-1:0] pattern_in,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [NUM_LEDS-1:0] led_out
);

    logic [CTRL_BITS-1:0]     ctrl_q;
    logic [PWM_BITS-1:0]      duty_q;
    logic [PRESCALE_BITS-1:0] prescale_q;
    logic [PRESCALE_BITS-1:0] blink_half_q;
    logic [NUM_LEDS-1:0]      pat_q;
    logic [PRESCALE_BITS-1:0] blink_cnt;
    logic                     blink_phase;

    logic                     wr_en;
    logic                     tick;
    logic [PWM_BITS-1:0]      pwm_cnt;
    logic                     per_end;
    logic                     pwm_on;
    logic                     unused_ok;

    assign wr_en     = chipselect && !write_n;
    assign pwm_on    = (pwm_cnt < duty_q);
    assign unused_ok = ^{writedata[31:PRESCALE_BITS], tick};

    led_tick_gen #(
        .PWM_BITS      (PWM_BITS),
        .PRESCALE_BITS (PRESCALE_BITS)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .prescale (prescale_q),
        .tick     (tick),
        .pwm_cnt  (pwm_cnt),
        .per_end  (per_end)
    );

    // Register file: word writes; counters are never disturbed by a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q       <= CTRL_RESET;
            duty_q       <= {PWM_BITS{1'b1}};
            prescale_q   <= '0;
            blink_half_q <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_CTRL:       ctrl_q       <= writedata[CTRL_BITS-1:0];
                ADDR_DUTY:       duty_q       <= writedata[PWM_BITS-1:0];
                ADDR_PRESCALE:   prescale_q   <= writedata[PRESCALE_BITS-1:0];
                default:         blink_half_q <= writedata[PRESCALE_BITS-1:0];
            endcase
        end
    end

    // Zero-wait read mux, unused bits read as zero.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:     readdata[CTRL_BITS-1:0]     = ctrl_q;
            ADDR_DUTY:     readdata[PWM_BITS-1:0]      = duty_q;
            ADDR_PRESCALE: readdata[PRESCALE_BITS-1:0] = prescale_q;
            default:       readdata[PRESCALE_BITS-1:0] = blink_half_q;
        endcase
    end

    // Pattern capture stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pat_q <= '0;
        else       pat_q <= pattern_in;
    end

    // Blink phase: counts PWM periods; disabling blink parks it visible so
    // re-enabling always starts with the LEDs shown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (!ctrl_q[CTRL_BLINK_EN]) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (per_end) begin
            if (blink_cnt == blink_half_q) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt   <= blink_cnt + 1'b1;
            end
        end
    end

    // Output stage: gate by PWM and blink, then apply polarity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            led_out <= '0;
        else if (ctrl_q[CTRL_ENABLE])
            led_out <= (pat_q & {NUM_LEDS{pwm_on & blink_phase}}) ^ {NUM_LEDS{ctrl_q[CTRL_INVERT]}};
        else
            led_out <= {NUM_LEDS{ctrl_q[CTRL_INVERT]}};
    end

endmodule

// File: tb/tb_led_pwm_blinker.sv
// Directed bench for led_pwm_blinker. Stimulus pushes expected led_out and
// readdata values tagged with the cycle they must appear in; a monitor
// compares them on the falling edge.
module tb_led_pwm_blinker;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pattern_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  led_out;

    typedef struct {
        int          cyc;
        logic [31:0] exp;
        int          sec;
    } chk_t;

    chk_t led_q[$];
    chk_t rd_q[$];

    int tcyc   = 0;   // posedges since time zero
    int r      = 0;   // tcyc at the last reset release
    int sec    = 0;
    int errors = 0;
    int checks = 0;

    led_pwm_blinker dut (
        .clk        (clk),
        .reset      (reset),
        .pattern_in (pattern_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led_out    (led_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tcyc <= tcyc + 1;

    // Monitor: compare every expectation tagged for this cycle.
    initial begin
        chk_t c;
        forever begin
            @(negedge clk);
            while (led_q.size() > 0 && led_q[0].cyc <= tcyc) begin
                c = led_q.pop_front();
                checks++;
                if (c.cyc != tcyc || led_out !== c.exp[7:0]) begin
                    errors++;
                    $display("FAIL led sec=%0d cyc=%0d at=%0d got=%h exp=%h",
                             c.sec, c.cyc - r, tcyc - r, led_out, c.exp[7:0]);
                end
            end
            while (rd_q.size() > 0 && rd_q[0].cyc <= tcyc) begin
                c = rd_q.pop_front();
                checks++;
                if (c.cyc != tcyc || readdata !== c.exp) begin
                    errors++;
                    $display("FAIL read sec=%0d addr=%0d got=%h exp=%h",
                             c.sec, address, readdata, c.exp);
                end
            end
        end
    end

    function automatic void exp_abs(int t, logic [7:0] v);
        chk_t c;
        c.cyc = t; c.exp = {24'h0, v}; c.sec = sec;
        led_q.push_back(c);
    endfunction

    // k = edges since the last reset release
    function automatic void exp_led(int k, logic [7:0] v);
        exp_abs(r + k, v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(int k);
        while (tcyc - r < k) step();
    endtask

    task automatic bus_write(logic [1:0] a, logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_chk(logic [1:0] a, logic [31:0] v);
        chk_t c;
        address = a;
        c.cyc = tcyc; c.exp = v; c.sec = sec;
        rd_q.push_back(c);
        step();
    endtask

    // Reset asserted just after an edge; led_out must already be 0 at the
    // following falling edge and stay 0 while held.
    task automatic do_reset();
        reset = 1'b1;
        chipselect = 1'b0; write_n = 1'b1;
        repeat (2) begin
            exp_abs(tcyc, 8'h00);
            step();
        end
        reset = 1'b0;
        r = tcyc;
    endtask

    task automatic drain();
        int n = 0;
        while ((led_q.size() != 0 || rd_q.size() != 0) && n < 5000) begin
            step();
            n++;
        end
        if (led_q.size() != 0 || rd_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain sec=%0d pending=%0d required=0", sec, led_q.size() + rd_q.size());
            led_q.delete();
            rd_q.delete();
        end
    endtask

    initial begin
        int w;
        int p0;
        reset = 1'b1; pattern_in = 8'h00; address = 2'd0;
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        step();

        // 1: defaults. PRESCALE=0 so pwm_cnt after edge k is k mod 256.
        sec = 1;
        pattern_in = 8'hA5;
        do_reset();
        exp_led(1, 8'h00);
        for (int k = 2; k <= 300; k++)
            exp_led(k, ((k - 1) % 256 != 255) ? 8'hA5 : 8'h00);
        rd_chk(2'd0, 32'h1);
        rd_chk(2'd1, 32'hFF);
        rd_chk(2'd2, 32'h0);
        rd_chk(2'd3, 32'h0);
        drain();

        // 2: dimming, DUTY=0x40 then DUTY=0.
        sec = 2;
        pattern_in = 8'hFF;
        do_reset();
        bus_write(2'd1, 32'h40);
        for (int k = 10; k <= 521; k++)
            exp_led(k, ((k - 1) % 256 < 64) ? 8'hFF : 8'h00);
        drain();
        bus_write(2'd1, 32'h0);
        w = tcyc - r;
        for (int k = w + 1; k <= w + 300; k++) exp_led(k, 8'h00);
        drain();

        // 3: PRESCALE=3 (write edge 1), DUTY=0x80 (edge 2).
        // Ticks at edge 1 and then edges 5,9,...: pwm after edge k = 1+(k-1)/4.
        sec = 3;
        do_reset();
        bus_write(2'd2, 32'h3);
        bus_write(2'd1, 32'h80);
        for (int k = 10; k <= 2110; k++)
            exp_led(k, (((1 + (k - 2) / 4) % 256) < 128) ? 8'hFF : 8'h00);
        drain();
        // Lower PRESCALE to 1 at an edge W with W%4==3: pre_cnt becomes 2,
        // already above the new value, so a tick follows at W+1, then every 2.
        w = tcyc - r + 2;
        while (w % 4 != 3) w++;
        wait_until(w - 1);
        bus_write(2'd2, 32'h1);
        p0 = 1 + (w - 1) / 4;
        for (int k = w + 1; k <= w + 600; k++)
            exp_led(k, (((p0 + (k - w) / 2) % 256) < 128) ? 8'hFF : 8'h00);
        drain();

        // 4: blink, BLINK_HALF=1: phase flips at edges 512, 1024, ...
        sec = 4;
        pattern_in = 8'h3C;
        do_reset();
        bus_write(2'd3, 32'h1);
        bus_write(2'd0, 32'h3);
        for (int k = 5; k <= 2100; k++)
            exp_led(k, (((k - 1) / 512) % 2 == 0 && (k - 1) % 256 != 255) ? 8'h3C : 8'h00);
        drain();
        // Clear blink_en at edge 2700 (dark phase): visible from edge 2702.
        for (int k = 2690; k <= 3000; k++)
            exp_led(k, (k > 2701 && (k - 1) % 256 != 255) ? 8'h3C : 8'h00);
        wait_until(2699);
        bus_write(2'd0, 32'h1);
        drain();

        // 5: invert, then invert with enable off.
        sec = 5;
        pattern_in = 8'h0F;
        do_reset();
        bus_write(2'd0, 32'h5);
        for (int k = 3; k <= 300; k++)
            exp_led(k, ((k - 1) % 256 != 255) ? 8'hF0 : 8'hFF);
        drain();
        bus_write(2'd0, 32'h4);
        w = tcyc - r;
        for (int k = w + 1; k <= w + 300; k++) exp_led(k, 8'hFF);
        drain();

        // 6: readback masking, BLINK_HALF=0 blink, async reset mid-visible.
        sec = 6;
        pattern_in = 8'hFF;
        do_reset();
        bus_write(2'd0, 32'hFFFF_FFF3);
        bus_write(2'd1, 32'hFFFF_FF10);
        bus_write(2'd3, 32'hABCD_0000);
        rd_chk(2'd0, 32'h3);
        rd_chk(2'd1, 32'h10);
        rd_chk(2'd2, 32'h0);
        rd_chk(2'd3, 32'h0);
        for (int k = 10; k <= 520; k++)
            exp_led(k, (((k - 1) / 256) % 2 == 0 && (k - 1) % 256 < 16) ? 8'hFF : 8'h00);
        wait_until(521);
        do_reset();
        for (int k = 2; k <= 300; k++)
            exp_led(k, ((k - 1) % 256 != 255) ? 8'hFF : 8'h00);
        rd_chk(2'd0, 32'h1);
        rd_chk(2'd1, 32'hFF);
        rd_chk(2'd2, 32'h0);
        rd_chk(2'd3, 32'h0);
        drain();
        bus_write(2'd0, 32'h3);
        w = tcyc - r;
        for (int k = w + 1; k <= w + 150; k++) exp_led(k, 8'hFF);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
